// File: rtl/sfp_ctrl.sv
// rtl/sfp_ctrl.sv - psum walk / SFP accumulate-ReLU sequencer for corelet
module sfp_ctrl #(
  parameter int PSUM_AW = 11,
  parameter int OUT_AW  = 4,
  parameter int PASS_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [OUT_AW:0]    num_vec,
  input  logic [PASS_W-1:0]  num_pass,
  input  logic [PSUM_AW-1:0] stride,
  output logic               psum_cen,
  output logic [PSUM_AW-1:0] psum_addr,
  output logic               acc_en,
  output logic               sfp_wr_en,
  output logic               out_wen,
  output logic [OUT_AW-1:0]  out_addr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t state, state_nx;

  logic [OUT_AW:0]    nv_q;
  logic [PASS_W-1:0]  np_q;
  logic [PSUM_AW-1:0] stride_q;
  logic [OUT_AW:0]    v_cnt;
  logic [PASS_W-1:0]  p_cnt;
  logic [PSUM_AW-1:0] addr_q;
  logic [1:0]         drain_cnt;

  // read-pipeline stages: c+1 (acc), c+2 (sfp write), c+3 (output write)
  logic               acc_q;
  logic               last1_q;
  logic [OUT_AW-1:0]  vec1_q;
  logic               sfp_q;
  logic [OUT_AW-1:0]  vec2_q;
  logic               wr_q;
  logic [OUT_AW-1:0]  oaddr_q;

  logic last_pass;
  logic last_rd;
  logic accept;

  assign last_pass = (p_cnt == np_q - 1'b1);
  assign last_rd   = last_pass && (v_cnt == nv_q - 1'b1);
  assign accept    = (state == IDLE) && start;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic; empty jobs skip straight to the done cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (num_vec != '0 && num_pass != '0) ? RUN : FIN;
      RUN:   if (last_rd) state_nx = DRAIN;
      DRAIN: if (drain_cnt == 2'd2) state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // config latch, pass/vector counters and address walk (stride added per pass)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nv_q      <= '0;
      np_q      <= '0;
      stride_q  <= '0;
      v_cnt     <= '0;
      p_cnt     <= '0;
      addr_q    <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        nv_q      <= num_vec;
        np_q      <= num_pass;
        stride_q  <= stride;
        v_cnt     <= '0;
        p_cnt     <= '0;
        addr_q    <= '0;
        drain_cnt <= '0;
      end else if (state == RUN && !last_rd) begin
        if (last_pass) begin
          p_cnt  <= '0;
          v_cnt  <= v_cnt + 1'b1;
          addr_q <= PSUM_AW'(v_cnt + 1'b1);
        end else begin
          p_cnt  <= p_cnt + 1'b1;
          addr_q <= addr_q + stride_q;
        end
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // strobe pipeline following each issued read; output address holds between writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= 1'b0;
      last1_q <= 1'b0;
      vec1_q  <= '0;
      sfp_q   <= 1'b0;
      vec2_q  <= '0;
      wr_q    <= 1'b0;
      oaddr_q <= '0;
    end else begin
      acc_q   <= (state == RUN);
      last1_q <= (state == RUN) && last_pass;
      vec1_q  <= v_cnt[OUT_AW-1:0];
      sfp_q   <= last1_q;
      vec2_q  <= vec1_q;
      wr_q    <= sfp_q;
      if (sfp_q) oaddr_q <= vec2_q;
    end
  end

  assign psum_cen  = (state != RUN);
  assign psum_addr = addr_q;
  assign acc_en    = acc_q;
  assign sfp_wr_en = sfp_q;
  assign out_wen   = ~wr_q;
  assign out_addr  = oaddr_q;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

endmodule
